cg_irq_pending: RTL and testbench

Edge-capturing interrupt pending/claim stage that sits directly upstream of `cg_priority_encoder` and consumes its result. Rising edges on up to `NUM_SRC` request lines are latched into a pending register and filtered by a mask. The highest-index pending line is selected, MSB highest priority, using the priority encoder. The selected ID is presented on a registered valid/ready claim port; an accepted claim clears that line's pending bit.

---
 rtl/cg_irq_pending.sv | 108 ++++++++++
 tb/tb_cg_irq_pending.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cg_irq_pending.sv
// ============================================================================
// cg_irq_pending : edge-capturing interrupt pending register with a claim port
// Revision: 1.0
// ============================================================================
`default_nettype none

module cg_priority_encoder #(
  parameter  int BITS_WIDTH = 16,
  localparam int IDX_W      = $clog2(BITS_WIDTH)
) (
  input  logic [BITS_WIDTH-1:0] i_bits,
  output logic                  o_en,
  output logic [IDX_W-1:0]      o_index
);

  // Ascending scan: the last set bit seen is the highest index, so MSB wins.
  always_comb begin
    o_en    = 1'b0;
    o_index = '0;
    for (int i = 0; i < BITS_WIDTH; i++) begin
      if (i_bits[i]) begin
        o_en    = 1'b1;
        o_index = IDX_W'(i);
      end
    end
  end

endmodule

module cg_irq_pending #(
  parameter  int NUM_SRC  = 16,
  localparam int ID_WIDTH = $clog2(NUM_SRC)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_SRC-1:0]  i_irq,
  input  logic                i_mask_we,
  input  logic [NUM_SRC-1:0]  i_mask_data,
  input  logic [NUM_SRC-1:0]  i_clear,
  output logic [NUM_SRC-1:0]  o_mask,
  output logic [NUM_SRC-1:0]  o_pending,
  output logic                o_valid,
  output logic [ID_WIDTH-1:0] o_id,
  input  logic                i_ready
);

  logic [NUM_SRC-1:0]  irq_q, irq_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  mask_q, mask_d;
  logic                valid_q, valid_d;
  logic [ID_WIDTH-1:0] id_q, id_d;

  logic [NUM_SRC-1:0]  rise;
  logic [NUM_SRC-1:0]  claim_clr;
  logic [NUM_SRC-1:0]  cand;
  logic                handshake;
  logic                load;
  logic                enc_en;
  logic [ID_WIDTH-1:0] enc_index;

  cg_priority_encoder #(
    .BITS_WIDTH (NUM_SRC)
  ) u_enc (
    .i_bits  (cand),
    .o_en    (enc_en),
    .o_index (enc_index)
  );

  always_comb begin
    handshake = valid_q & i_ready;
    claim_clr = handshake ? (NUM_SRC'(1) << id_q) : '0;
    rise      = i_irq & ~irq_q;
    // The line being taken this cycle is excluded so back-to-back claims move on.
    cand      = pending_q & mask_q & ~claim_clr & ~i_clear;
    load      = ~valid_q | i_ready;

    irq_d     = i_irq;
    pending_d = (pending_q & ~i_clear & ~claim_clr) | rise;
    mask_d    = i_mask_we ? i_mask_data : mask_q;
    valid_d   = load ? enc_en    : valid_q;
    id_d      = load ? enc_index : id_q;
  end

  // irq_q resets high so lines already asserted at reset release are not edges.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      irq_q     <= '1;
      pending_q <= '0;
      mask_q    <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
    end else begin
      irq_q     <= irq_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
    end
  end

  assign o_mask    = mask_q;
  assign o_pending = pending_q;
  assign o_valid   = valid_q;
  assign o_id      = id_q;

endmodule

`default_nettype wire

// File: tb/tb_cg_irq_pending.sv
// Directed bench for cg_irq_pending; outputs are sampled 1 time unit after posedge.
`default_nettype none

module tb_cg_irq_pending;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] irq;
  logic        mask_we;
  logic [15:0] mask_data;
  logic [15:0] clr;
  logic [15:0] mask;
  logic [15:0] pending;
  logic        valid;
  logic [3:0]  id;
  logic        ready;

  int n_vec = 0;
  int n_err = 0;

  cg_irq_pending #(.NUM_SRC(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_irq       (irq),
    .i_mask_we   (mask_we),
    .i_mask_data (mask_data),
    .i_clear     (clr),
    .o_mask      (mask),
    .o_pending   (pending),
    .o_valid     (valid),
    .o_id        (id),
    .i_ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_mask(input logic [15:0] m);
    mask_we   = 1'b1;
    mask_data = m;
    tick();
    mask_we   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq = 16'hFFFF; mask_we = 1'b0; mask_data = '0; clr = '0; ready = 1'b0;

    // Reset with all lines held high
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_pending", {16'd0, pending}, 32'd0);
      check("rst_mask", {16'd0, mask}, 32'd0);
      check("rst_id", {28'd0, id}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("idle_valid", {31'd0, valid}, 32'd0);
    check("idle_pending", {16'd0, pending}, 32'd0);
    irq = '0;
    tick();
    check("fall_pending", {16'd0, pending}, 32'd0);

    // Single claim
    write_mask(16'hFFFF);
    check("mask_ffff", {16'd0, mask}, 32'h0000FFFF);
    ready = 1'b1;
    irq = 16'h0020; tick();
    check("single_pend", {16'd0, pending}, 32'h0020);
    check("single_novalid", {31'd0, valid}, 32'd0);
    irq = '0; tick();
    check("single_valid", {31'd0, valid}, 32'd1);
    check("single_id", {28'd0, id}, 32'd5);
    tick();
    check("single_done_valid", {31'd0, valid}, 32'd0);
    check("single_done_pend", {16'd0, pending}, 32'd0);

    // Priority, back-to-back
    irq = 16'h8208; tick();
    check("prio_pend", {16'd0, pending}, 32'h8208);
    irq = '0; tick();
    check("prio_v0", {31'd0, valid}, 32'd1);
    check("prio_id15", {28'd0, id}, 32'd15);
    tick();
    check("prio_id9", {28'd0, id}, 32'd9);
    check("prio_pend2", {16'd0, pending}, 32'h0208);
    tick();
    check("prio_id3", {28'd0, id}, 32'd3);
    check("prio_v2", {31'd0, valid}, 32'd1);
    tick();
    check("prio_end_valid", {31'd0, valid}, 32'd0);
    check("prio_end_pend", {16'd0, pending}, 32'd0);

    // Hold under backpressure
    ready = 1'b0;
    irq = 16'h0004; tick();
    irq = '0; tick();
    check("hold_id2", {28'd0, id}, 32'd2);
    irq = 16'h4000; tick();
    check("hold_pend", {16'd0, pending}, 32'h4004);
    check("hold_id_hi", {28'd0, id}, 32'd2);
    irq = '0;
    write_mask(16'hFFFB);
    check("hold_id_masked", {28'd0, id}, 32'd2);
    tick(); tick();
    check("hold_id_late", {28'd0, id}, 32'd2);
    check("hold_valid_late", {31'd0, valid}, 32'd1);
    ready = 1'b1; tick();
    check("hold_next_valid", {31'd0, valid}, 32'd1);
    check("hold_next_id14", {28'd0, id}, 32'd14);
    check("hold_next_pend", {16'd0, pending}, 32'h4000);
    tick();
    check("hold_end_valid", {31'd0, valid}, 32'd0);
    check("hold_end_pend", {16'd0, pending}, 32'd0);

    // Mask gating
    write_mask(16'h0000);
    irq = 16'h0080; tick();
    irq = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("gate_pend7", {31'd0, pending[7]}, 32'd1);
      check("gate_novalid", {31'd0, valid}, 32'd0);
    end
    write_mask(16'h0080);
    check("gate_write_valid", {31'd0, valid}, 32'd0);
    tick();
    check("gate_valid", {31'd0, valid}, 32'd1);
    check("gate_id7", {28'd0, id}, 32'd7);
    tick();
    check("gate_end_valid", {31'd0, valid}, 32'd0);

    // Handshake coinciding with a new edge on the same line
    write_mask(16'hFFFF);
    ready = 1'b0;
    irq = 16'h0010; tick();
    irq = '0; tick();
    check("re_id4", {28'd0, id}, 32'd4);
    ready = 1'b1; irq = 16'h0010; tick();
    check("re_hs_pend4", {31'd0, pending[4]}, 32'd1);
    check("re_hs_gap", {31'd0, valid}, 32'd0);
    irq = '0; tick();
    check("re_hs_valid", {31'd0, valid}, 32'd1);
    check("re_hs_id4", {28'd0, id}, 32'd4);
    tick();
    check("re_hs_end", {31'd0, valid}, 32'd0);

    // i_clear coinciding with a new edge; held claim still delivered
    ready = 1'b0;
    irq = 16'h0010; tick();
    irq = '0; tick();
    clr = 16'h0010; irq = 16'h0010; tick();
    check("re_clr_pend4", {31'd0, pending[4]}, 32'd1);
    check("re_clr_id4", {28'd0, id}, 32'd4);
    clr = '0; irq = '0; tick();
    clr = 16'h0010; tick();
    check("clr_only_pend", {16'd0, pending}, 32'd0);
    check("clr_held_valid", {31'd0, valid}, 32'd1);
    check("clr_held_id", {28'd0, id}, 32'd4);
    clr = '0; ready = 1'b1; tick();
    check("clr_held_done", {31'd0, valid}, 32'd0);

    // Reset mid-claim drops the claim
    ready = 1'b0;
    irq = 16'h0100; tick();
    irq = '0; tick();
    check("mid_valid", {31'd0, valid}, 32'd1);
    ready = 1'b1; rst_n = 1'b0; tick();
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_pend", {16'd0, pending}, 32'd0);
    check("mid_rst_mask", {16'd0, mask}, 32'd0);
    rst_n = 1'b1; tick();
    check("post_rst_valid", {31'd0, valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
